// File: rtl/pulse_burst_gen.sv
// ============================================================================
// pulse_burst_gen : emits a start-requested burst of single-cycle pulses on x,
//                   spaced by GAP idle cycles, flagging GROUP-modulo rollovers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pulse_burst_gen #(
    parameter int COUNT_W = 8,
    parameter int GAP     = 1,
    parameter int GROUP   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] count,
    output logic               ready,
    output logic               busy,
    output logic               x,
    output logic               wrap,
    output logic               done,
    output logic [COUNT_W-1:0] sent
);

    localparam int GAP_W = ($clog2(GAP + 1) > 0) ? $clog2(GAP + 1) : 1;
    localparam int GRP_W = $clog2(GROUP);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] rem_q, rem_d;
    logic [COUNT_W-1:0] sent_q, sent_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               x_q, x_d;
    logic               wrap_q, wrap_d;
    logic               done_q, done_d;

    // Counters advance on the edge that enters a pulse cycle, so the
    // registered sent/wrap already describe the pulse being shown on x.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sent_d  = sent_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        state_d = S_DONE;
                        sent_d  = '0;
                    end else begin
                        state_d = S_PULSE;
                        rem_d   = count - COUNT_W'(1);
                        sent_d  = COUNT_W'(1);
                    end
                end
            end
            S_PULSE: begin
                if (rem_q == '0) begin
                    state_d = S_DONE;
                end else if (GAP == 0) begin
                    rem_d  = rem_q - COUNT_W'(1);
                    sent_d = sent_q + COUNT_W'(1);
                end else begin
                    state_d = S_GAP;
                    gap_d   = GAP_LAST;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_PULSE;
                    rem_d   = rem_q - COUNT_W'(1);
                    sent_d  = sent_q + COUNT_W'(1);
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        x_d     = (state_d == S_PULSE);
        wrap_d  = x_d && (sent_d[GRP_W-1:0] == '0);
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d == S_PULSE) || (state_d == S_GAP);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            sent_q  <= '0;
            gap_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            x_q     <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sent_q  <= sent_d;
            gap_q   <= gap_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            x_q     <= x_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign x     = x_q;
    assign wrap  = wrap_q;
    assign done  = done_q;
    assign sent  = sent_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_burst_gen.sv
// ============================================================================
// tb_pulse_burst_gen : drives a GAP=1 and a GAP=0 instance in lockstep and
//                      checks every cycle against the burst timing formulas.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pulse_burst_gen;

    localparam int CW  = 8;
    localparam int GRP = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] count;
    logic          rcv_clr;

    logic          ready0, busy0, x0, wrap0, done0;
    logic [CW-1:0] sent0;
    logic          ready1, busy1, x1, wrap1, done1;
    logic [CW-1:0] sent1;

    logic [1:0]    rcnt;
    logic          z;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pulse_burst_gen #(.COUNT_W(CW), .GAP(1), .GROUP(GRP)) u_dut_g1 (
        .clk(clk), .reset(reset), .start(start), .count(count),
        .ready(ready0), .busy(busy0), .x(x0), .wrap(wrap0), .done(done0), .sent(sent0)
    );

    pulse_burst_gen #(.COUNT_W(CW), .GAP(0), .GROUP(GRP)) u_dut_g0 (
        .clk(clk), .reset(reset), .start(start), .count(count),
        .ready(ready1), .busy(busy1), .x(x1), .wrap(wrap1), .done(done1), .sent(sent1)
    );

    // 2-bit pulse-counting receiver on the GAP=1 instance; cleared per burst.
    always @(posedge clk) begin
        if (reset || rcv_clr) begin
            rcnt <= 2'd0;
            z    <= 1'b0;
        end else begin
            z <= x0 && (rcnt == 2'd3);
            if (x0) rcnt <= rcnt + 2'd1;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int burst_len(input int g, input int n);
        return (n == 0) ? 1 : (n - 1) * (g + 1) + 2;
    endfunction

    // Expected outputs in cycle j after the start edge; j beyond the burst means idle.
    task automatic check_dut(input string nm, input int g, input int n, input int j,
                             input logic r, input logic b, input logic xx,
                             input logic w, input logic d, input logic [CW-1:0] s);
        int L, es;
        bit er, eb, ex, ew, ed;
        L = burst_len(g, n);
        er = 0; eb = 0; ex = 0; ew = 0; ed = 0; es = n;
        if (j >= L + 1) begin
            er = 1;
        end else if (j == L) begin
            ed = 1;
        end else begin
            eb = 1;
            ex = ((j - 1) % (g + 1)) == 0;
            es = (j - 1) / (g + 1) + 1;
            ew = ex && (es % GRP == 0);
        end
        check({nm, ".ready"}, int'(r), int'(er));
        check({nm, ".busy"},  int'(b), int'(eb));
        check({nm, ".x"},     int'(xx), int'(ex));
        check({nm, ".wrap"},  int'(w), int'(ew));
        check({nm, ".done"},  int'(d), int'(ed));
        check({nm, ".sent"},  int'(s), es);
    endtask

    task automatic check_both(input int n, input int j);
        check_dut("g1", 1, n, j, ready0, busy0, x0, wrap0, done0, sent0);
        check_dut("g0", 0, n, j, ready1, busy1, x1, wrap1, done1, sent1);
    endtask

    // One burst of length n; optional ignored-start noise and reset abort at cycle abort_j.
    task automatic run_burst(input int n, input bit noise, input int abort_j);
        int  lmin, lmax;
        bit  prev_w, aborted;
        lmin = (burst_len(1, n) < burst_len(0, n)) ? burst_len(1, n) : burst_len(0, n);
        lmax = (burst_len(1, n) > burst_len(0, n)) ? burst_len(1, n) : burst_len(0, n);
        @(negedge clk);
        start = 1'b1; count = CW'(n); rcv_clr = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rcv_clr = 1'b0;
        prev_w = 1'b0; aborted = 1'b0;
        for (int j = 1; j <= lmax + 1; j++) begin
            if (aborted) begin
                check_both(0, 1000);
                check("rcv.z", int'(z), 0);
                break;
            end
            check_both(n, j);
            check("rcv.z", int'(z), int'(prev_w));
            prev_w = wrap0;
            @(negedge clk);
            if (j == abort_j) begin
                reset = 1'b1;
                aborted = 1'b1;
            end else if (noise && j <= lmin && ($urandom % 3 == 0)) begin
                start = 1'b1;
                count = CW'($urandom_range(1, 255));
            end
            @(posedge clk); #1;
            start = 1'b0;
            reset = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; count = '0; rcv_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_both(0, 1000);
            @(posedge clk); #1;
        end

        run_burst(5, 1'b0, 0);
        run_burst(255, 1'b0, 0);
        run_burst(0, 1'b0, 0);
        run_burst(3, 1'b0, 0);
        run_burst(4, 1'b1, 0);
        run_burst(6, 1'b0, 5);
        run_burst(2, 1'b0, 0);

        for (int k = 0; k < 25; k++) begin
            int n, ab;
            n  = ($urandom % 6 == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(0, 12));
            ab = ($urandom % 5 == 0) ? int'($urandom_range(1, burst_len(0, n))) : 0;
            run_burst(n, $urandom % 2 == 1, ab);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
